// File: rtl/img_stream_ctrl.sv
// Frame sequencer: streams a stored RGB frame as R,G,B bytes with VSYNC/HSYNC/EN framing.
// Optional feature macro FRAME_LOOP_EN adds a `loop` input for back-to-back frames.
module img_stream_ctrl #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int VS_CYC  = 8,
    parameter int VBP_CYC = 8,
    parameter int HB_CYC  = 4,
    parameter int ADDR_W  = 20
) (
    input  logic              clk_sys,
    input  logic              reset_sys,
    input  logic              start,
`ifdef FRAME_LOOP_EN
    input  logic              loop,
`endif
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              OutVSYNC,
    output logic              OutHSYNC,
    output logic              OutEN,
    output logic [7:0]        OutData
);

    localparam int LINE_LEN = 3 * IMG_W;
    localparam int MAX_AB   = (VS_CYC > VBP_CYC) ? VS_CYC : VBP_CYC;
    localparam int MAX_CD   = (LINE_LEN > HB_CYC) ? LINE_LEN : HB_CYC;
    localparam int MAX_CYC  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W    = $clog2(MAX_CYC + 1);
    localparam int LINE_W   = $clog2(IMG_H + 1);

    typedef enum logic [2:0] {
        IDLE,
        VS,
        VBP,
        LINE,
        HBL,
        DONE
    } ctrlStateT;

    ctrlStateT         stateReg;
    ctrlStateT         stateNext;
    logic [CNT_W-1:0]  phaseCntReg;
    logic [LINE_W-1:0] lineCntReg;
    logic [ADDR_W-1:0] rdAddrReg;
    logic              phaseEnd;
    logic              lastLine;
    logic              lastByte;
    logic              enterVs;
    logic              loopReq;

    // Two-stage framing pipeline matches the one-cycle memory read plus the OutData register.
    logic [1:0]        vsPipeReg;
    logic [1:0]        lnPipeReg;
    logic [1:0]        lastPipeReg;
    logic              doneReg;
    logic [7:0]        dataReg;

`ifdef FRAME_LOOP_EN
    assign loopReq = loop;
`else
    assign loopReq = 1'b0;
`endif

    assign lastLine = (lineCntReg == LINE_W'(IMG_H - 1));
    assign lastByte = (stateReg == LINE) && phaseEnd && lastLine;
    assign enterVs  = (stateNext == VS) && (stateReg != VS);

    always_ff @(posedge clk_sys or negedge reset_sys) begin
        if (!reset_sys) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        phaseEnd  = 1'b0;
        case (stateReg)
            IDLE: begin
                if (start) begin
                    stateNext = VS;
                end
            end
            VS: begin
                phaseEnd = (phaseCntReg == CNT_W'(VS_CYC - 1));
                if (phaseEnd) begin
                    stateNext = VBP;
                end
            end
            VBP: begin
                phaseEnd = (phaseCntReg == CNT_W'(VBP_CYC - 1));
                if (phaseEnd) begin
                    stateNext = LINE;
                end
            end
            LINE: begin
                phaseEnd = (phaseCntReg == CNT_W'(LINE_LEN - 1));
                if (phaseEnd) begin
                    stateNext = HBL;
                end
            end
            HBL: begin
                phaseEnd = (phaseCntReg == CNT_W'(HB_CYC - 1));
                if (phaseEnd) begin
                    if (!lastLine) begin
                        stateNext = LINE;
                    end else if (loopReq) begin
                        stateNext = VS;
                    end else begin
                        stateNext = DONE;
                    end
                end
            end
            DONE: begin
                phaseEnd  = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Phase counter restarts on every state change; all transitions out of a busy state happen at phaseEnd.
    always_ff @(posedge clk_sys or negedge reset_sys) begin
        if (!reset_sys) begin
            phaseCntReg <= '0;
            lineCntReg  <= '0;
            rdAddrReg   <= '0;
        end else begin
            if (stateReg == IDLE || phaseEnd) begin
                phaseCntReg <= '0;
            end else begin
                phaseCntReg <= phaseCntReg + CNT_W'(1);
            end

            if (stateReg == VS) begin
                lineCntReg <= '0;
            end else if (stateReg == HBL && phaseEnd) begin
                lineCntReg <= lineCntReg + LINE_W'(1);
            end

            if (enterVs) begin
                rdAddrReg <= '0;
            end else if (stateReg == LINE) begin
                rdAddrReg <= rdAddrReg + ADDR_W'(1);
            end
        end
    end

    // done trails the final read by three cycles: memory latency, OutData register, then one cycle after.
    always_ff @(posedge clk_sys or negedge reset_sys) begin
        if (!reset_sys) begin
            vsPipeReg   <= '0;
            lnPipeReg   <= '0;
            lastPipeReg <= '0;
            doneReg     <= 1'b0;
            dataReg     <= '0;
        end else begin
            vsPipeReg   <= {vsPipeReg[0], (stateReg == VS)};
            lnPipeReg   <= {lnPipeReg[0], (stateReg == LINE)};
            lastPipeReg <= {lastPipeReg[0], lastByte};
            doneReg     <= lastPipeReg[1];
            if (lnPipeReg[0]) begin
                dataReg <= rd_data;
            end
        end
    end

    assign busy     = (stateReg != IDLE);
    assign rd_en    = (stateReg == LINE);
    assign rd_addr  = rdAddrReg;
    assign done     = doneReg;
    assign OutVSYNC = vsPipeReg[1];
    assign OutHSYNC = lnPipeReg[1];
    assign OutEN    = lnPipeReg[1];
    assign OutData  = dataReg;

endmodule
